// File: rtl/os_array_ctrl.sv
// Sequencer for an output-stationary systolic array: clear, feed K beats, flush wavefront, drain rows.
// Latency: start at t -> done at t + 2 + k_len + (ROWS+COLS-2) + ROWS; feed_stall and out_ready gate FEED and DRAIN.
module os_array_ctrl #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int K_W  = 8,
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [K_W-1:0] k_len,
    input  logic           feed_stall,
    input  logic           out_ready,
    output logic           busy,
    output logic           pe_clear,
    output logic           pipeline_en,
    output logic           feed_valid,
    output logic [K_W-1:0] feed_idx,
    output logic           out_valid,
    output logic [RW-1:0]  drain_row,
    output logic           done
);

    localparam int FLUSH_N = ROWS + COLS - 2;
    localparam int FW      = (FLUSH_N > 1) ? $clog2(FLUSH_N) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        FLUSH,
        DRAIN,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [K_W-1:0] k_len_q, k_len_d;
    logic [K_W-1:0] feed_idx_q, feed_idx_d;
    logic [FW-1:0]  flush_cnt_q, flush_cnt_d;
    logic [RW-1:0]  drain_row_q, drain_row_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_len_q     <= '0;
            feed_idx_q  <= '0;
            flush_cnt_q <= '0;
            drain_row_q <= '0;
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            feed_idx_q  <= feed_idx_d;
            flush_cnt_q <= flush_cnt_d;
            drain_row_q <= drain_row_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        feed_idx_d  = feed_idx_q;
        flush_cnt_d = flush_cnt_q;
        drain_row_d = drain_row_q;
        busy        = (state_q != IDLE);
        pe_clear    = 1'b0;
        pipeline_en = 1'b0;
        feed_valid  = 1'b0;
        out_valid   = 1'b0;
        done        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && (k_len != '0)) begin
                    k_len_d    = k_len;
                    feed_idx_d = '0;
                    state_d    = CLEAR;
                end
            end
            CLEAR: begin
                pe_clear   = 1'b1;
                feed_idx_d = '0;
                state_d    = FEED;
            end
            FEED: begin
                feed_valid  = !feed_stall;
                pipeline_en = !feed_stall;
                if (!feed_stall) begin
                    // Last beat holds the index rather than stepping past k_len-1.
                    if (feed_idx_q == k_len_q - K_W'(1)) begin
                        flush_cnt_d = '0;
                        drain_row_d = '0;
                        state_d     = (FLUSH_N == 0) ? DRAIN : FLUSH;
                    end else begin
                        feed_idx_d = feed_idx_q + K_W'(1);
                    end
                end
            end
            FLUSH: begin
                pipeline_en = 1'b1;
                if (flush_cnt_q == FW'(FLUSH_N - 1)) begin
                    drain_row_d = '0;
                    state_d     = DRAIN;
                end else begin
                    flush_cnt_d = flush_cnt_q + FW'(1);
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (drain_row_q == RW'(ROWS - 1)) begin
                        state_d = DONE;
                    end else begin
                        drain_row_d = drain_row_q + RW'(1);
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign feed_idx  = feed_idx_q;
    assign drain_row = drain_row_q;

endmodule
